// File: rtl/qar_timer_pkg.sv
// Shared timer/sequencer address map and the sequencer step state type.
package qar_timer_pkg;

  localparam logic [5:0] TMR_CTRL_ADDR      = 6'h00;
  localparam logic [5:0] TMR_STATUS_ADDR    = 6'h03;
  localparam logic [5:0] TMR_PWM0_DUTY_ADDR = 6'h0D;
  localparam logic [5:0] TMR_PWM1_DUTY_ADDR = 6'h0F;
  localparam logic [5:0] TMR_CAPTURE1_ADDR  = 6'h13;

  localparam logic [4:0] SEQ_CTRL_ADDR       = 5'h00;
  localparam logic [4:0] SEQ_LEN_ADDR        = 5'h01;
  localparam logic [4:0] SEQ_STATUS_ADDR     = 5'h02;
  localparam logic [4:0] SEQ_INDEX_ADDR      = 5'h03;
  localparam logic [4:0] SEQ_ACK_MASK_ADDR   = 5'h04;
  localparam logic [4:0] SEQ_TABLE_BASE_ADDR = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_DUTY,
    ST_WR_ACK
  } seq_state_e;

endpackage

// File: rtl/qar_seq_table.sv
// Duty table: DEPTH x 32 register file, one write port, cfg and step read ports.
module qar_seq_table #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  cfg_raddr,
  output logic [31:0] cfg_rdata,
  input  logic [3:0]  step_raddr,
  output logic [31:0] step_rdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr[AW-1:0]] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign cfg_rdata  = mem_q[cfg_raddr[AW-1:0]];
  assign step_rdata = mem_q[step_raddr[AW-1:0]];

endmodule

// File: rtl/qar_pwm_sequencer.sv
// PWM duty sequencer: on each tick edge writes the next table entry to the timer
// duty register (plus optional status ack), sharing the timer port with the CPU.
module qar_pwm_sequencer
  import qar_timer_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter logic [5:0]  DUTY0_ADDR  = TMR_PWM0_DUTY_ADDR,
  parameter logic [5:0]  DUTY1_ADDR  = TMR_PWM1_DUTY_ADDR,
  parameter logic [5:0]  STATUS_ADDR = TMR_STATUS_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_write,
  input  logic        cfg_read,
  input  logic [4:0]  cfg_addr_word,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  input  logic        cpu_write,
  input  logic        cpu_read,
  input  logic [5:0]  cpu_addr_word,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        tmr_write,
  output logic        tmr_read,
  output logic [5:0]  tmr_addr_word,
  output logic [31:0] tmr_wdata,
  input  logic [31:0] tmr_rdata,
  input  logic        tick
);

  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  seq_state_e  state_q, state_d;
  logic        enable_q, enable_d, loop_q, loop_d, chan_q, chan_d;
  logic [4:0]  len_q, len_d;
  logic        done_q, done_d, overrun_q, overrun_d;
  logic [3:0]  index_q, index_d;
  logic [31:0] ack_mask_q, ack_mask_d;
  logic        pending_q, pending_d, tick_q, tick_d;

  logic        tick_edge, seq_idle, cpu_req, advance, last_entry, busy;
  logic        table_hit, table_we;
  logic        ctrl_wr, len_wr, status_wr, mask_wr;
  logic [31:0] tbl_cfg_rdata, tbl_step_rdata;

  assign tick_edge  = tick & ~tick_q;
  assign seq_idle   = (state_q == ST_IDLE);
  assign cpu_req    = cpu_write | cpu_read;
  assign busy       = pending_q | ~seq_idle;
  assign last_entry = ({1'b0, index_q} == (len_q - 5'd1));
  assign table_hit  = cfg_addr_word[4] && ({1'b0, cfg_addr_word[3:0]} < DEPTH_L);
  assign table_we   = cfg_write && table_hit;
  assign ctrl_wr    = cfg_write && (cfg_addr_word == SEQ_CTRL_ADDR);
  assign len_wr     = cfg_write && (cfg_addr_word == SEQ_LEN_ADDR);
  assign status_wr  = cfg_write && (cfg_addr_word == SEQ_STATUS_ADDR);
  assign mask_wr    = cfg_write && (cfg_addr_word == SEQ_ACK_MASK_ADDR);

  qar_seq_table #(.DEPTH(DEPTH)) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (table_we),
    .waddr      (cfg_addr_word[3:0]),
    .wdata      (cfg_wdata),
    .cfg_raddr  (cfg_addr_word[3:0]),
    .cfg_rdata  (tbl_cfg_rdata),
    .step_raddr (index_q),
    .step_rdata (tbl_step_rdata)
  );

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (pending_q && !cpu_req) state_d = ST_WR_DUTY;
      ST_WR_DUTY: begin
        if (ack_mask_q != '0) begin
          state_d = ST_WR_ACK;
        end else begin
          state_d = ST_IDLE;
          advance = 1'b1;
        end
      end
      ST_WR_ACK: begin
        state_d = ST_IDLE;
        advance = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_write     = cpu_write;
    tmr_read      = cpu_read;
    tmr_addr_word = cpu_addr_word;
    tmr_wdata     = cpu_wdata;
    cpu_rdata     = tmr_rdata;
    cpu_stall     = 1'b0;
    if (!seq_idle) begin
      tmr_write     = 1'b1;
      tmr_read      = 1'b0;
      cpu_rdata     = '0;
      cpu_stall     = cpu_req;
      tmr_addr_word = STATUS_ADDR;
      tmr_wdata     = ack_mask_q;
      if (state_q == ST_WR_DUTY) begin
        tmr_addr_word = chan_q ? DUTY1_ADDR : DUTY0_ADDR;
        tmr_wdata     = tbl_step_rdata;
      end
    end
  end

  // Ordering below: cfg writes, then tick/pending, then advance, so hardware sets win.
  always_comb begin
    enable_d   = enable_q;
    loop_d     = loop_q;
    chan_d     = chan_q;
    len_d      = len_q;
    done_d     = done_q;
    overrun_d  = overrun_q;
    index_d    = index_q;
    ack_mask_d = ack_mask_q;
    pending_d  = pending_q;
    tick_d     = tick;

    if (ctrl_wr) begin
      enable_d = cfg_wdata[0];
      loop_d   = cfg_wdata[1];
      chan_d   = cfg_wdata[2];
      if (cfg_wdata[0] && !enable_q) begin
        index_d = '0;
        done_d  = 1'b0;
      end
    end
    if (len_wr)  len_d = (cfg_wdata[4:0] > DEPTH_L) ? DEPTH_L : cfg_wdata[4:0];
    if (mask_wr) ack_mask_d = cfg_wdata;
    if (status_wr) begin
      if (cfg_wdata[1]) done_d    = 1'b0;
      if (cfg_wdata[2]) overrun_d = 1'b0;
    end

    if (seq_idle && (state_d != ST_IDLE)) pending_d = 1'b0;
    if (tick_edge) begin
      if (busy) overrun_d = 1'b1;
      else if (enable_q && (len_q != '0)) pending_d = 1'b1;
    end
    if (ctrl_wr && (!cfg_wdata[0] || !enable_q)) pending_d = 1'b0;

    if (advance) begin
      if (last_entry) begin
        index_d = '0;
        if (!loop_q) begin
          done_d   = 1'b1;
          enable_d = 1'b0;
        end
      end else begin
        index_d = index_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      enable_q   <= 1'b0;
      loop_q     <= 1'b0;
      chan_q     <= 1'b0;
      len_q      <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      index_q    <= '0;
      ack_mask_q <= '0;
      pending_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      loop_q     <= loop_d;
      chan_q     <= chan_d;
      len_q      <= len_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      index_q    <= index_d;
      ack_mask_q <= ack_mask_d;
      pending_q  <= pending_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    if (cfg_read) begin
      if (table_hit) begin
        cfg_rdata = tbl_cfg_rdata;
      end else begin
        unique case (cfg_addr_word)
          SEQ_CTRL_ADDR:     cfg_rdata = {29'd0, chan_q, loop_q, enable_q};
          SEQ_LEN_ADDR:      cfg_rdata = {27'd0, len_q};
          SEQ_STATUS_ADDR:   cfg_rdata = {29'd0, overrun_q, done_q, busy};
          SEQ_INDEX_ADDR:    cfg_rdata = {28'd0, index_q};
          SEQ_ACK_MASK_ADDR: cfg_rdata = ack_mask_q;
          default:           cfg_rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qar_pwm_sequencer.sv
// Scoreboard bench: stimulus pushes expected timer writes, a negedge monitor pops and compares.
module tb_qar_pwm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_write = 1'b0, cfg_read = 1'b0;
  logic [4:0]  cfg_addr_word = '0;
  logic [31:0] cfg_wdata = '0, cfg_rdata;
  logic        cpu_write = 1'b0, cpu_read = 1'b0;
  logic [5:0]  cpu_addr_word = '0;
  logic [31:0] cpu_wdata = '0, cpu_rdata;
  logic        cpu_stall;
  logic        tmr_write, tmr_read;
  logic [5:0]  tmr_addr_word;
  logic [31:0] tmr_wdata;
  logic [31:0] tmr_rdata = '0;
  logic        tick = 1'b0;

  qar_pwm_sequencer #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_write(cfg_write), .cfg_read(cfg_read), .cfg_addr_word(cfg_addr_word),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_addr_word(cpu_addr_word),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .tmr_write(tmr_write), .tmr_read(tmr_read), .tmr_addr_word(tmr_addr_word),
    .tmr_wdata(tmr_wdata), .tmr_rdata(tmr_rdata), .tick(tick)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
    int unsigned c;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model of the sequencer's architectural state.
  logic        m_en, m_loop, m_chan, m_done, m_ovr;
  int unsigned m_len, m_idx;
  logic [31:0] m_mask;
  logic [31:0] m_tbl [16];

  function automatic void model_reset();
    m_en = 0; m_loop = 0; m_chan = 0; m_done = 0; m_ovr = 0;
    m_len = 0; m_idx = 0; m_mask = '0;
    for (int i = 0; i < 16; i++) m_tbl[i] = '0;
  endfunction

  function automatic void model_step(input int unsigned n, input int unsigned lat);
    exp_q.push_back('{a: (m_chan ? 6'hF : 6'hD), d: m_tbl[m_idx], c: n + lat});
    if (m_mask != 0) exp_q.push_back('{a: 6'h3, d: m_mask, c: n + lat + 1});
    if (m_idx == m_len - 1) begin
      m_idx = 0;
      if (!m_loop) begin
        m_done = 1;
        m_en = 0;
      end
    end else begin
      m_idx = m_idx + 1;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && tmr_write) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL tmr_write_unexpected: got addr=%h data=%h cycle=%0d, required no write",
                 tmr_addr_word, tmr_wdata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (tmr_addr_word !== mon_e.a || tmr_wdata !== mon_e.d || cyc != mon_e.c) begin
          n_bad++;
          $display("FAIL tmr_write: got addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d",
                   tmr_addr_word, tmr_wdata, cyc, mon_e.a, mon_e.d, mon_e.c);
        end
      end
    end
  end

  task automatic nxt(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    cfg_write = 1; cfg_addr_word = a; cfg_wdata = d;
    case (a)
      5'h0: begin
        if (d[0] && !m_en) begin m_idx = 0; m_done = 0; end
        m_en = d[0]; m_loop = d[1]; m_chan = d[2];
      end
      5'h1: m_len = (d[4:0] > 16) ? 16 : int'(d[4:0]);
      5'h2: begin
        if (d[1]) m_done = 0;
        if (d[2]) m_ovr = 0;
      end
      5'h4: m_mask = d;
      default: if (a >= 5'h10) m_tbl[a - 5'h10] = d;
    endcase
    nxt();
    cfg_write = 0;
  endtask

  task automatic cfg_rd(input logic [4:0] a, output logic [31:0] d);
    cfg_read = 1; cfg_addr_word = a;
    #1 d = cfg_rdata;
    cfg_read = 0;
    #1;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    cfg_rd(5'h0, v); check({tag, "_ctrl"}, v, {29'd0, m_chan, m_loop, m_en});
    cfg_rd(5'h2, v); check({tag, "_status"}, v, {29'd0, m_ovr, m_done, 1'b0});
    cfg_rd(5'h3, v); check({tag, "_index"}, v, m_idx);
  endtask

  task automatic tick_go(input int unsigned gap);
    tick = 1;
    if (m_en && m_len != 0) model_step(cyc, 2);
    nxt();
    tick = 0;
    nxt(gap);
  endtask

  initial begin
    logic [31:0] v;
    int unsigned n0, nt;
    model_reset();
    nxt(3);
    rst_n = 1;
    nxt();

    check_regs("reset");
    cfg_rd(5'h1, v);  check("reset_len", v, 0);
    cfg_rd(5'h4, v);  check("reset_mask", v, 0);
    cfg_rd(5'h10, v); check("reset_table0", v, 0);
    cfg_rd(5'h5, v);  check("unmapped_read", v, 0);
    check("reset_stall", cpu_stall, 0);

    // CPU pass-through while idle
    cpu_write = 1; cpu_addr_word = 6'hD; cpu_wdata = 5;
    exp_q.push_back('{a: 6'hD, d: 32'd5, c: cyc});
    #1 check("idle_wr_stall", cpu_stall, 0);
    nxt();
    cpu_write = 0; cpu_read = 1; cpu_addr_word = 6'h3; tmr_rdata = 32'hA5A5_0001;
    #1 check("idle_rd_tmr_read", tmr_read, 1);
    check("idle_rd_addr", tmr_addr_word, 6'h3);
    check("idle_rd_data", cpu_rdata, 32'hA5A5_0001);
    nxt();
    cpu_read = 0;

    // One-shot sequence
    cfg_wr(5'h10, 10); cfg_wr(5'h11, 20); cfg_wr(5'h12, 30);
    cfg_wr(5'h1, 3); cfg_wr(5'h4, 0); cfg_wr(5'h0, 1);
    repeat (3) tick_go(5);
    check_regs("oneshot");

    // Loop on pwm1 with ack
    cfg_wr(5'h10, 4); cfg_wr(5'h11, 8); cfg_wr(5'h1, 2); cfg_wr(5'h4, 1); cfg_wr(5'h0, 7);
    repeat (4) tick_go(5);
    check_regs("loop");

    // CPU holds the port across the tick edge
    cfg_wr(5'h4, 0);
    n0 = cyc;
    tick = 1; cpu_write = 1; cpu_read = 0; cpu_addr_word = 6'h0; cpu_wdata = 32'h11;
    exp_q.push_back('{a: 6'h0, d: 32'h11, c: n0});
    exp_q.push_back('{a: 6'h0, d: 32'h11, c: n0 + 1});
    model_step(n0, 3);
    nxt();
    tick = 0;
    nxt();
    cpu_write = 0;
    nxt();
    cpu_read = 1; cpu_addr_word = 6'h3;
    #1 check("busy_stall", cpu_stall, 1);
    check("busy_tmr_read", tmr_read, 0);
    check("busy_cpu_rdata", cpu_rdata, 0);
    nxt();
    check("after_stall", cpu_stall, 0);
    check("after_tmr_read", tmr_read, 1);
    cpu_read = 0;
    nxt(3);

    // Second edge during WR_DUTY is dropped and flagged
    tick = 1; model_step(cyc, 2);
    nxt(); tick = 0;
    nxt(); tick = 1; m_ovr = 1;
    nxt(); tick = 0;
    nxt(4);
    check_regs("overrun");
    cfg_wr(5'h2, 4);
    check_regs("overrun_w1c");

    // Randomized programs
    for (int r = 0; r < 6; r++) begin
      cfg_wr(5'h0, 0);
      for (int i = 0; i < 16; i++) cfg_wr(5'(16 + i), $urandom);
      cfg_wr(5'h1, $urandom_range(1, 31));
      cfg_rd(5'h1, v); check("rand_len_clamp", v, m_len);
      cfg_wr(5'h4, ($urandom_range(0, 1) != 0) ? $urandom : 32'd0);
      cfg_wr(5'h0, {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
      nt = $urandom_range(1, m_len + 3);
      repeat (nt) tick_go($urandom_range(4, 7));
      nxt(2);
      check_regs("rand");
    end

    // Reset while the duty write is on the bus
    cfg_wr(5'h0, 0); cfg_wr(5'h10, 32'h77); cfg_wr(5'h1, 1); cfg_wr(5'h4, 0); cfg_wr(5'h0, 1);
    tick = 1; nxt(); tick = 0; nxt();
    check("pre_reset_write", tmr_write, 1);
    rst_n = 0;
    #1 check("reset_kills_write", tmr_write, 0);
    model_reset();
    nxt(2);
    rst_n = 1;
    nxt();
    check_regs("post_reset");

    nxt(3);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qar_pwm_sequencer.md
Name: qar_pwm_sequencer

Overview:
Hardware duty-cycle sequencer for the timer's PWM channels. It holds a small table of duty values. On each rising edge of a tick input (normally the timer irq or a compare status), it writes the next entry into the timer's PWM duty register and can optionally W1C-acknowledge the timer status. It sits between the CPU bus and the timer register port, shares that port with the CPU, and stalls the CPU while it owns the port.

Parameters:
DEPTH, 16, number of table entries (power of two, max 16)
DUTY0_ADDR, 6'hD, timer word address of pwm0 duty
DUTY1_ADDR, 6'hF, timer word address of pwm1 duty
STATUS_ADDR, 6'h3, timer word address of W1C status

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_write  in  1  sequencer register write strobe
cfg_read  in  1  sequencer register read strobe
cfg_addr_word  in  5  sequencer register word address
cfg_wdata  in  32  sequencer write data
cfg_rdata  out  32  sequencer read data (combinational; 0 when !cfg_read)
cpu_write  in  1  CPU timer write request
cpu_read  in  1  CPU timer read request
cpu_addr_word  in  6  CPU timer word address
cpu_wdata  in  32  CPU timer write data
cpu_rdata  out  32  timer read data to CPU
cpu_stall  out  1  CPU access refused this cycle; CPU must hold request
tmr_write  out  1  to timer bus_write
tmr_read  out  1  to timer bus_read
tmr_addr_word  out  6  to timer addr_word
tmr_wdata  out  32  to timer wdata
tmr_rdata  in  32  from timer rdata
tick  in  1  step trigger, rising-edge sensitive

Behaviour:
- Registers (word address):
  - 0x0 CTRL: [0] enable, [1] loop, [2] channel (0 = pwm0, 1 = pwm1).
  - 0x1 LEN [4:0]: valid 1..DEPTH; 0 = ticks ignored.
  - 0x2 STATUS: [0] busy (RO), [1] done (sticky, W1C), [2] overrun (sticky, W1C).
  - 0x3 INDEX (RO).
  - 0x4 ACK_MASK: 32 bits; 0 = no ack write.
  - 0x10+i TABLE[i], i < DEPTH.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset: all registers, index, pending and tick_q are 0; FSM in IDLE. Outputs then mirror the CPU inputs, and cpu_stall = 0.
- Edge detect: tick_q <= tick; edge = tick & ~tick_q.
- FSM states: IDLE, WR_DUTY, WR_ACK.
  - IDLE: tmr_* = cpu_*; cpu_rdata = tmr_rdata; cpu_stall = 0.
  - IDLE -> WR_DUTY when pending && !(cpu_write | cpu_read). CPU has priority in IDLE.
  - WR_DUTY: one cycle; tmr_write = 1, tmr_addr_word = DUTYn_ADDR, tmr_wdata = TABLE[index] (value at that cycle).
  - WR_DUTY -> WR_ACK if ACK_MASK != 0, else -> IDLE with advance.
  - WR_ACK: one cycle; tmr_write = 1, addr = STATUS_ADDR, wdata = ACK_MASK; -> IDLE with advance.
  - While in WR_DUTY or WR_ACK: tmr_read = 0; cpu_stall = cpu_write | cpu_read; cpu_rdata = 0.
- Pending:
  - Set on edge when enable && LEN != 0.
  - Cleared when leaving IDLE.
  - Edge while pending or FSM != IDLE sets overrun; that tick is dropped.
- Advance:
  - If index == LEN-1: with loop, index <= 0; without loop, index <= 0, done <= 1, enable <= 0.
  - Otherwise index <= index + 1.
  - index is 4 bits, wrap-free by the rule above.
- Latency: tick first high in cycle N, no CPU traffic -> duty write visible in cycle N+2, ack in N+3.
- Enable 0->1 via CTRL write: index <= 0, pending <= 0, done <= 0.
- CTRL write clearing enable: pending cleared; an in-flight step completes, including its advance.
- busy = pending | (FSM != IDLE).
- Simultaneous cfg STATUS W1C and hardware set in the same cycle: the hardware set wins.
- LEN > DEPTH is clamped to DEPTH on write.
- Reset mid-step abandons the write; tmr_write is 0 immediately on reset assertion.

Decomposition:
- Shared package qar_timer_pkg: timer register word addresses (CTRL 0x0 … CAPTURE1 0x13), sequencer register addresses, FSM state encoding localparams.
- One natural sub-module: qar_seq_table, the DEPTH x 32 register file with one write port and two combinational read ports (cfg and step).

Test Plan:
- Reset, then CPU write 0xD = 5 with sequencer idle -> tmr_write = 1, addr 0xD, wdata 5 the same cycle; cpu_stall = 0.
- TABLE = {10, 20, 30}, LEN = 3, CTRL = 0x1, ACK_MASK = 0; three tick pulses -> writes of 10, 20, 30 to addr 0xD at N+2; done = 1, enable = 0, INDEX = 0.
- CTRL = 0x7 (loop, pwm1), ACK_MASK = 1, LEN = 2, table {4, 8}; four ticks -> addr 0xF writes 4, 8, 4, 8, each followed next cycle by write addr 0x3 data 1; done stays 0.
- CPU write held during the tick edge cycle and the next cycle -> sequencer waits; WR_DUTY occurs the cycle after CPU request drops; cpu_stall asserted if CPU requests during WR_DUTY.
- Second tick edge arriving while in WR_DUTY -> overrun = 1, only one duty write; W1C 0x4 to STATUS clears overrun.
- rst_n low during WR_DUTY -> tmr_write = 0 at once; after release INDEX = 0, STATUS = 0, CTRL = 0.
